// File: rtl/sprite_pixel_fetch_if.sv
// Sprite pixel fetch bus: pixel request fields, the shared ROM port and the
// registered pixel result. The fetch block is the slave; whoever issues
// requests and hosts the character ROMs is the master.
interface sprite_pixel_fetch_if #(
  parameter int NUM_TYPES = 8,
  parameter int ADDR_W    = 13,
  parameter int PIX_W     = 2,
  parameter int TYPE_W    = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1
);
  logic                        req_valid;
  logic [TYPE_W-1:0]           req_type;
  logic [7:0]                  req_x;
  logic [7:0]                  req_y;
  logic [7:0]                  req_width;
  logic [7:0]                  req_height;
  logic [1:0]                  req_frame;
  logic [ADDR_W-1:0]           req_frame_size;
  logic                        req_flip;
  logic [ADDR_W-1:0]           rom_addr;
  logic [NUM_TYPES*PIX_W-1:0]  rom_data;
  logic                        pix_valid;
  logic [PIX_W-1:0]            pix_value;
  logic                        pix_opaque;

  modport master (
    output req_valid, req_type, req_x, req_y, req_width, req_height,
           req_frame, req_frame_size, req_flip, rom_data,
    input  rom_addr, pix_valid, pix_value, pix_opaque
  );

  modport slave (
    input  req_valid, req_type, req_x, req_y, req_width, req_height,
           req_frame, req_frame_size, req_flip, rom_data,
    output rom_addr, pix_valid, pix_value, pix_opaque
  );
endinterface

// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetch: turns a sprite-local (x,y) request into a shared ROM
// address, carries the request's type and range flag alongside the ROM read,
// then picks the addressed type's slot from the concatenated ROM outputs.
// Fixed latency, one request per cycle, no backpressure.
module sprite_pixel_fetch #(
  parameter int NUM_TYPES = 8,
  parameter int ADDR_W    = 13,
  parameter int PIX_W     = 2,
  parameter int ROM_LAT   = 1,
  parameter int TYPE_W    = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  sprite_pixel_fetch_if.slave bus
);
  localparam logic [PIX_W-1:0] TRANSP = {PIX_W{1'b1}};

  logic [7:0]        w_x_eff;
  logic [ADDR_W-1:0] w_addr;
  logic              w_oor;
  logic [PIX_W-1:0]  w_slots [NUM_TYPES];
  logic [PIX_W-1:0]  w_slot_sel;
  logic [PIX_W-1:0]  w_pix;

  logic [ADDR_W-1:0] r_rom_addr;
  logic [ROM_LAT:0]  r_vld_pipe;
  logic [ROM_LAT:0]  r_oor_pipe;
  logic [TYPE_W-1:0] r_type_pipe [ROM_LAT+1];
  logic              r_pix_valid;
  logic [PIX_W-1:0]  r_pix_value;
  logic              r_pix_opaque;

  // Address and range check for the request on the bus this cycle. The sum is
  // modular, so only its low ADDR_W bits are ever observable; computing it
  // directly at ADDR_W gives the same wrapped address.
  always_comb begin
    w_x_eff = bus.req_flip ? (bus.req_width - 8'd1 - bus.req_x) : bus.req_x;
    w_addr  = ADDR_W'(bus.req_frame) * bus.req_frame_size
            + ADDR_W'(bus.req_y) * ADDR_W'(bus.req_width)
            + ADDR_W'(w_x_eff);
    w_oor   = (bus.req_x >= bus.req_width) || (bus.req_y >= bus.req_height) ||
              (bus.req_width == 8'd0) || (int'(bus.req_type) >= NUM_TYPES);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TYPES; gi++) begin : g_slot
      assign w_slots[gi] = bus.rom_data[gi*PIX_W +: PIX_W];
    end
  endgenerate

  // Slot mux for the request whose ROM data is arriving; a type with no ROM
  // falls through to the transparent code (its range flag is set anyway).
  always_comb begin
    w_slot_sel = TRANSP;
    for (int k = 0; k < NUM_TYPES; k++) begin
      if (r_type_pipe[ROM_LAT] == TYPE_W'(k)) begin
        w_slot_sel = w_slots[k];
      end
    end
    w_pix = r_oor_pipe[ROM_LAT] ? TRANSP : w_slot_sel;
  end

  // Stage 0: register the ROM address (held when idle) and the request tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rom_addr     <= '0;
      r_vld_pipe[0]  <= 1'b0;
      r_oor_pipe[0]  <= 1'b0;
      r_type_pipe[0] <= '0;
    end else begin
      r_vld_pipe[0] <= bus.req_valid;
      if (bus.req_valid) begin
        r_rom_addr     <= w_addr;
        r_oor_pipe[0]  <= w_oor;
        r_type_pipe[0] <= bus.req_type;
      end
    end
  end

  // Tag shift pipeline that keeps pace with the ROM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 1; s <= ROM_LAT; s++) begin
        r_vld_pipe[s]  <= 1'b0;
        r_oor_pipe[s]  <= 1'b0;
        r_type_pipe[s] <= '0;
      end
    end else begin
      for (int s = 1; s <= ROM_LAT; s++) begin
        r_vld_pipe[s]  <= r_vld_pipe[s-1];
        r_oor_pipe[s]  <= r_oor_pipe[s-1];
        r_type_pipe[s] <= r_type_pipe[s-1];
      end
    end
  end

  // Output stage: value holds between results, opaque only with a valid strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_valid  <= 1'b0;
      r_pix_value  <= '0;
      r_pix_opaque <= 1'b0;
    end else if (r_vld_pipe[ROM_LAT]) begin
      r_pix_valid  <= 1'b1;
      r_pix_value  <= w_pix;
      r_pix_opaque <= (w_pix != TRANSP);
    end else begin
      r_pix_valid  <= 1'b0;
      r_pix_opaque <= 1'b0;
    end
  end

  assign bus.rom_addr   = r_rom_addr;
  assign bus.pix_valid  = r_pix_valid;
  assign bus.pix_value  = r_pix_value;
  assign bus.pix_opaque = r_pix_opaque;
endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Bench for sprite_pixel_fetch: two instances (8 and 6 character types) share
// one request stream; a queue-based model predicts every result and rom_addr.
module tb_sprite_pixel_fetch;
  localparam int ROM_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_type = '0;
  logic [7:0]  req_x = '0, req_y = '0, req_width = '0, req_height = '0;
  logic [1:0]  req_frame = '0;
  logic [12:0] req_frame_size = '0;
  logic        req_flip = 1'b0;

  always #5 clk = ~clk;

  sprite_pixel_fetch_if #(.NUM_TYPES(8), .ADDR_W(13), .PIX_W(2), .TYPE_W(3)) if8 ();
  sprite_pixel_fetch_if #(.NUM_TYPES(6), .ADDR_W(13), .PIX_W(2), .TYPE_W(3)) if6 ();

  assign if8.req_valid = req_valid;          assign if6.req_valid = req_valid;
  assign if8.req_type = req_type;            assign if6.req_type = req_type;
  assign if8.req_x = req_x;                  assign if6.req_x = req_x;
  assign if8.req_y = req_y;                  assign if6.req_y = req_y;
  assign if8.req_width = req_width;          assign if6.req_width = req_width;
  assign if8.req_height = req_height;        assign if6.req_height = req_height;
  assign if8.req_frame = req_frame;          assign if6.req_frame = req_frame;
  assign if8.req_frame_size = req_frame_size; assign if6.req_frame_size = req_frame_size;
  assign if8.req_flip = req_flip;            assign if6.req_flip = req_flip;

  sprite_pixel_fetch #(.NUM_TYPES(8), .ADDR_W(13), .PIX_W(2), .ROM_LAT(ROM_LAT), .TYPE_W(3))
    dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  sprite_pixel_fetch #(.NUM_TYPES(6), .ADDR_W(13), .PIX_W(2), .ROM_LAT(ROM_LAT), .TYPE_W(3))
    dut6 (.clk(clk), .rst(rst), .bus(if6.slave));

  // ROM contents: slot k at address a holds (a + k + 1) mod 4.
  function automatic logic [1:0] rom_fn(input int k, input int a);
    return 2'((a + k + 1) % 4);
  endfunction

  function automatic int calc_addr(input int fr, input int fs, input int y,
                                   input int w, input int x, input int fl);
    int xe;
    xe = (fl != 0) ? (w - 1 - x) : x;
    return (fr * fs + y * w + xe) % 8192;
  endfunction

  function automatic bit is_oor(input int t, input int x, input int y,
                                input int w, input int h, input int nt);
    return (x >= w) || (y >= h) || (w == 0) || (t >= nt);
  endfunction

  // Synchronous ROMs with one cycle of read latency.
  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) if8.rom_data[k*2 +: 2] <= rom_fn(k, int'(if8.rom_addr));
    for (int k = 0; k < 6; k++) if6.rom_data[k*2 +: 2] <= rom_fn(k, int'(if6.rom_addr));
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         due;
    logic [1:0] v8;
    logic [1:0] v6;
  } exp_t;

  exp_t       q[$];
  int         m_addr = 0;
  logic [1:0] last8 = '0, last6 = '0;
  int         obs_v[$];
  int         obs_c[$];

  // Model: each accepted request becomes one expected result due a fixed
  // number of cycles later; reset discards everything outstanding.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_addr = 0;
      last8  = '0;
      last6  = '0;
    end else begin
      cyc++;
      if (req_valid) begin
        int   a;
        exp_t e;
        a = calc_addr(int'(req_frame), int'(req_frame_size), int'(req_y),
                      int'(req_width), int'(req_x), int'(req_flip));
        m_addr = a;
        e.due = cyc + ROM_LAT + 1;
        e.v8  = is_oor(int'(req_type), int'(req_x), int'(req_y), int'(req_width),
                       int'(req_height), 8) ? 2'b11 : rom_fn(int'(req_type), a);
        e.v6  = is_oor(int'(req_type), int'(req_x), int'(req_y), int'(req_width),
                       int'(req_height), 6) ? 2'b11 : rom_fn(int'(req_type), a);
        q.push_back(e);
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid8", 32'(if8.pix_valid), 0);
      chk("rst_value8", 32'(if8.pix_value), 0);
      chk("rst_opaque8", 32'(if8.pix_opaque), 0);
      chk("rst_addr8", 32'(if8.rom_addr), 0);
      chk("rst_valid6", 32'(if6.pix_valid), 0);
    end else begin
      bit exp_v;
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      chk("valid8", 32'(if8.pix_valid), 32'(exp_v));
      chk("valid6", 32'(if6.pix_valid), 32'(exp_v));
      if (exp_v) begin
        exp_t e;
        e = q.pop_front();
        chk("value8", 32'(if8.pix_value), 32'(e.v8));
        chk("opaque8", 32'(if8.pix_opaque), 32'(e.v8 != 2'b11));
        chk("value6", 32'(if6.pix_value), 32'(e.v6));
        chk("opaque6", 32'(if6.pix_opaque), 32'(e.v6 != 2'b11));
        last8 = e.v8;
        last6 = e.v6;
      end else begin
        chk("hold_value8", 32'(if8.pix_value), 32'(last8));
        chk("idle_opaque8", 32'(if8.pix_opaque), 0);
        chk("hold_value6", 32'(if6.pix_value), 32'(last6));
        chk("idle_opaque6", 32'(if6.pix_opaque), 0);
      end
      if ((q.size() > 0) && (q[0].due < cyc)) begin
        chk("overdue_result", 32'(q[0].due), 32'(cyc));
        void'(q.pop_front());
      end
      chk("rom_addr8", 32'(if8.rom_addr), 32'(m_addr));
      chk("rom_addr6", 32'(if6.rom_addr), 32'(m_addr));
      if (if8.pix_valid) begin
        obs_v.push_back(int'(if8.pix_value));
        obs_c.push_back(cyc);
        $display("result cycle %0d: value8=%0d opaque8=%0b value6=%0d opaque6=%0b",
                 cyc, if8.pix_value, if8.pix_opaque, if6.pix_value, if6.pix_opaque);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int t, input int x, input int y, input int w, input int h,
                         input int fr, input int fs, input int fl);
    req_valid      = 1'b1;
    req_type       = 3'(t);
    req_x          = 8'(x);
    req_y          = 8'(y);
    req_width      = 8'(w);
    req_height     = 8'(h);
    req_frame      = 2'(fr);
    req_frame_size = 13'(fs);
    req_flip       = 1'(fl);
  endtask

  typedef struct {int t, x, y, w, h, fr, fs, fl, gap;} vec_t;
  vec_t tbl[8];
  int   bexp[4];

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the stimulus completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    tbl[0] = '{4, 7, 3, 16, 16, 2, 300, 0, 0};
    tbl[1] = '{5, 0, 0, 0, 4, 0, 10, 0, 1};
    tbl[2] = '{6, 1, 9, 8, 8, 0, 0, 0, 0};
    tbl[3] = '{6, 2, 1, 8, 8, 1, 50, 1, 2};
    tbl[4] = '{1, 10, 200, 250, 250, 3, 8000, 0, 0};
    tbl[5] = '{7, 0, 7, 8, 8, 0, 0, 1, 1};
    tbl[6] = '{2, 9, 0, 9, 5, 0, 0, 0, 0};
    tbl[7] = '{0, 254, 254, 255, 255, 3, 8191, 1, 3};
    bexp[0] = 1; bexp[1] = 2; bexp[2] = 3; bexp[3] = 0;

    repeat (3) tick();
    chk("lit_reset_valid", 32'(if8.pix_valid), 0);
    chk("lit_reset_addr", 32'(if8.rom_addr), 0);
    chk("model_addr_a", 32'(calc_addr(1, 1600, 2, 40, 5, 0)), 1685);
    chk("model_addr_b", 32'(calc_addr(0, 1600, 2, 40, 5, 1)), 114);
    rst = 1'b0;

    // First cycle after reset: frame 1, no flip.
    set_req(3, 5, 2, 40, 40, 1, 1600, 0); tick(); req_valid = 1'b0;
    chk("lit_addr_1685", 32'(if8.rom_addr), 1685);
    tick(); tick();
    chk("lit_valid_a", 32'(if8.pix_valid), 1);
    chk("lit_value_a", 32'(if8.pix_value), 1);
    chk("lit_opaque_a", 32'(if8.pix_opaque), 1);

    // Mirrored, frame 0.
    set_req(3, 5, 2, 40, 40, 0, 1600, 1); tick(); req_valid = 1'b0;
    chk("lit_addr_114", 32'(if8.rom_addr), 114);
    tick(); tick();
    chk("lit_value_b", 32'(if8.pix_value), 2);

    // Column at the width boundary: forced transparent, address still updates.
    set_req(0, 40, 0, 40, 40, 0, 100, 0); tick(); req_valid = 1'b0;
    chk("lit_addr_oor", 32'(if8.rom_addr), 40);
    tick(); tick();
    chk("lit_valid_oor", 32'(if8.pix_valid), 1);
    chk("lit_value_oor", 32'(if8.pix_value), 3);
    chk("lit_opaque_oor", 32'(if8.pix_opaque), 0);

    // Type 7: real ROM on the 8-type block, missing on the 6-type block.
    set_req(7, 2, 1, 10, 10, 0, 0, 0); tick(); req_valid = 1'b0;
    tick(); tick();
    chk("lit_value_t7_8", 32'(if8.pix_value), 0);
    chk("lit_opaque_t7_8", 32'(if8.pix_opaque), 1);
    chk("lit_value_t7_6", 32'(if6.pix_value), 3);
    chk("lit_opaque_t7_6", 32'(if6.pix_opaque), 0);

    // Mixed table with gaps.
    foreach (tbl[i]) begin
      set_req(tbl[i].t, tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h,
              tbl[i].fr, tbl[i].fs, tbl[i].fl);
      tick();
      if (tbl[i].gap > 0) begin
        req_valid = 1'b0;
        repeat (tbl[i].gap) tick();
      end
    end
    req_valid = 1'b0;
    repeat (4) tick();

    // Four-request burst, types 0..3 at address 0.
    obs_v.delete(); obs_c.delete();
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      set_req(k, 0, 0, 8, 8, 0, 0, 0);
      tick();
    end
    req_valid = 1'b0;
    repeat (5) tick();
    chk("burst_count", 32'(obs_v.size()), 4);
    for (int i = 0; i < 4 && i < obs_v.size(); i++) begin
      chk("burst_value", 32'(obs_v[i]), 32'(bexp[i]));
      chk("burst_cycle", 32'(obs_c[i]), 32'(c0 + 3 + i));
    end

    // Reset pulse in the second cycle of a burst.
    obs_v.delete(); obs_c.delete();
    set_req(0, 1, 1, 8, 8, 0, 0, 0); tick();
    set_req(2, 2, 2, 8, 8, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("async_valid", 32'(if8.pix_valid), 0);
    chk("async_value", 32'(if8.pix_value), 0);
    chk("async_opaque", 32'(if8.pix_opaque), 0);
    chk("async_addr", 32'(if8.rom_addr), 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1 rst = 1'b0;
    c0 = cyc;
    set_req(1, 3, 0, 8, 8, 0, 0, 0); tick(); req_valid = 1'b0;
    repeat (5) tick();
    chk("post_rst_count", 32'(obs_v.size()), 1);
    if (obs_v.size() > 0) begin
      chk("post_rst_value", 32'(obs_v[0]), 1);
      chk("post_rst_cycle", 32'(obs_c[0]), 32'(c0 + 3));
    end

    repeat (6) tick();
    chk("drain", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
